// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encoding, parity type and transmit FSM states.
package uart_pkg;

  typedef logic [1:0] parity_t;

  localparam parity_t PAR_NONE = 2'b00;
  localparam parity_t PAR_ODD  = 2'b01;
  localparam parity_t PAR_EVEN = 2'b10;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  // 2'b11 is treated like NONE: no parity bit on the line.
  function automatic logic parity_enabled(parity_t p);
    return (p == PAR_ODD) || (p == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// Byte-level request/status bundle between a transmit client and the framer.
interface uart_tx_framer_if;
  import uart_pkg::*;

  logic       tx_start;
  logic [7:0] tx_data;
  parity_t    parity_type;
  logic       tx_out;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_start, tx_data, parity_type,
    input  tx_out, tx_busy, tx_done
  );

  modport slave (
    input  tx_start, tx_data, parity_type,
    output tx_out, tx_busy, tx_done
  );

endinterface

// File: rtl/uart_parity_calc.sv
// Expected parity bit for a byte; shared by the transmit framer and the receive checker.
module uart_parity_calc
  import uart_pkg::*;
(
  input  logic [7:0] data_i,
  input  parity_t    parity_type_i,
  output logic       parity_o
);

  // EVEN makes the total count of ones even, ODD makes it odd.
  always_comb begin
    parity_o = 1'b0;
    case (parity_type_i)
      PAR_EVEN: parity_o = ^data_i;
      PAR_ODD:  parity_o = ~^data_i;
      default:  parity_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, 8 data bits LSB first, optional parity, stop bit(s).
//
// state     | meaning
// TX_IDLE   | line high, waiting for tx_start
// TX_START  | start bit (low)
// TX_DATA   | data bits, LSB first, shift register drives the line
// TX_PARITY | latched parity bit
// TX_STOP   | stop bit(s) high; last line cycle is the IDLE/tx_done cycle
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic clk,
  input  logic rst,
  uart_tx_framer_if.slave tx_if
);

  localparam int CNT_W = $clog2(2 * CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  // The final stop cycle coincides with the IDLE cycle that pulses tx_done,
  // so STOP itself ends one cycle early to keep the line high for exactly
  // STOP_BITS*CLKS_PER_BIT cycles and allow gapless back-to-back frames.
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 2);

  tx_state_e        state_q,   state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q,   shift_d;
  parity_t          ptype_q,   ptype_d;
  logic             par_bit_q, par_bit_d;
  logic             tx_out_q,  tx_out_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             par_calc;

  uart_parity_calc u_parity (
    .data_i        (tx_if.tx_data),
    .parity_type_i (tx_if.parity_type),
    .parity_o      (par_calc)
  );

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptype_d   = ptype_q;
    par_bit_d = par_bit_q;

    case (state_q)
      TX_IDLE: begin
        if (tx_if.tx_start && !busy_q) begin
          shift_d   = tx_if.tx_data;
          ptype_d   = tx_if.parity_type;
          par_bit_d = par_calc;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = TX_START;
        end
      end
      TX_START: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          state_d   = TX_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
            state_d   = parity_enabled(ptype_q) ? TX_PARITY : TX_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      TX_PARITY: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          state_d   = TX_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      TX_STOP: begin
        if (clk_cnt_q == STOP_LAST) begin
          clk_cnt_d = '0;
          state_d   = TX_IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      default: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        state_d   = TX_IDLE;
      end
    endcase

    case (state_d)
      TX_START:  tx_out_d = 1'b0;
      TX_DATA:   tx_out_d = shift_d[0];
      TX_PARITY: tx_out_d = par_bit_d;
      default:   tx_out_d = 1'b1;
    endcase

    busy_d = (state_d != TX_IDLE);
    done_d = (state_q == TX_STOP) && (state_d == TX_IDLE);
  end

  // State, datapath and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptype_q   <= PAR_NONE;
      par_bit_q <= 1'b0;
      tx_out_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptype_q   <= ptype_d;
      par_bit_q <= par_bit_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx_if.tx_out  = tx_out_q;
  assign tx_if.tx_busy = busy_q;
  assign tx_if.tx_done = done_q;

endmodule
